// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared definitions for the traffic sensor conditioner: lane count, one-hot
// lane constants, default timing parameters and a one-hot check helper.
package traffic_pkg;

    localparam int NUM_LANES = 4;

    typedef logic [NUM_LANES-1:0] lane_mask_t;

    localparam lane_mask_t LANE1 = 4'b0001;
    localparam lane_mask_t LANE2 = 4'b0010;
    localparam lane_mask_t LANE3 = 4'b0100;
    localparam lane_mask_t LANE4 = 4'b1000;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 8;
    localparam int DEFAULT_STUCK_CYCLES    = 1000;

    // True when exactly one lane bit is set; zero or multi-bit masks are rejected.
    function automatic logic is_one_hot(input lane_mask_t v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/traffic_sensor_conditioner_if.sv
// Bundle between the loop sensors / light controller and the conditioner.
// The master side drives raw sensors and the controller's phase info; the
// slave side (the conditioner) returns demand, debounced levels and stuck flags.
interface traffic_sensor_conditioner_if;
    import traffic_pkg::*;

    lane_mask_t raw_in;
    lane_mask_t side;
    logic       next;
    lane_mask_t t_req;
    lane_mask_t sensed;
    logic       any_req;
    lane_mask_t stuck;

    modport master (
        output raw_in, side, next,
        input  t_req, sensed, any_req, stuck
    );

    modport slave (
        input  raw_in, side, next,
        output t_req, sensed, any_req, stuck
    );

endinterface

// File: rtl/traffic_sensor_conditioner_debounce.sv
// Single-lane front end: two-flop synchroniser, consecutive-sample debounce
// counter, registered debounced level and a pulse marking its rising edge.
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int DB_W            = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic sensed,
    output logic rise
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            s1;
    logic            s2;
    logic            sensed_prev;
    logic [DB_W-1:0] cnt;

    // Bring the asynchronous loop input into the clock domain; plain flop chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Flip the debounced level only after an unbroken run of disagreeing samples;
    // any agreeing sample restarts the run so short glitches are swallowed.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            sensed      <= 1'b0;
            sensed_prev <= 1'b0;
        end else begin
            sensed_prev <= sensed;
            if (s2 == sensed) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                sensed <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = sensed & ~sensed_prev;

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Top of the sensor conditioner: per-lane debounce front ends feeding sticky
// request latches that are cleared when the controller finishes a lane's phase.
// Optional build macro STUCK_DETECT_EN adds per-lane stuck-sensor detection
// that flags a loop held high too long and suppresses its request.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int DB_W            = 4,
    parameter int STUCK_CYCLES    = DEFAULT_STUCK_CYCLES,
    parameter int STUCK_W         = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    traffic_sensor_conditioner_if.slave  bus
);

    // Reject parameter sets whose counters could not hold their terminal value.
    if ((DEBOUNCE_CYCLES < 2) || ((2 ** DB_W) <= DEBOUNCE_CYCLES)) begin : g_bad_db_cfg
        $error("debounce parameters out of range");
    end
    if ((2 ** STUCK_W) <= STUCK_CYCLES) begin : g_bad_stuck_cfg
        $error("stuck parameters out of range");
    end

    lane_mask_t sensed_w;
    lane_mask_t rise;
    lane_mask_t clr;
    lane_mask_t t_req_q;
    lane_mask_t t_req_next;
    lane_mask_t stuck_q;
    lane_mask_t stuck_next;
    logic       any_req_q;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        sensor_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .DB_W            (DB_W)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .raw    (bus.raw_in[i]),
            .sensed (sensed_w[i]),
            .rise   (rise[i])
        );
    end

    // A malformed side mask must not clear anything, so only a clean one-hot
    // value qualifies the controller's phase-done pulse.
    assign clr = (bus.next && is_one_hot(bus.side)) ? bus.side : '0;

`ifdef STUCK_DETECT_EN
    localparam logic [STUCK_W-1:0] SCNT_MAX = STUCK_W'(STUCK_CYCLES);

    logic [STUCK_W-1:0] scnt      [NUM_LANES];
    logic [STUCK_W-1:0] scnt_next [NUM_LANES];

    // Count consecutive debounced-high cycles per lane, saturating at the limit,
    // and raise stuck once the limit is reached until the level drops.
    always_comb begin
        stuck_next = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            scnt_next[i] = '0;
            if (sensed_w[i]) begin
                scnt_next[i] = (scnt[i] == SCNT_MAX) ? SCNT_MAX : scnt[i] + 1'b1;
            end
            stuck_next[i] = sensed_w[i] & (stuck_q[i] | (scnt_next[i] == SCNT_MAX));
        end
    end

    // Hold the stuck counters and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                scnt[i] <= '0;
            end
            stuck_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                scnt[i] <= scnt_next[i];
            end
            stuck_q <= stuck_next;
        end
    end
`else
    assign stuck_next = '0;
    assign stuck_q    = '0;
`endif

    // New arrivals win over a same-cycle clear; stuck lanes never request.
    always_comb begin
        t_req_next = (rise | (t_req_q & ~clr)) & ~stuck_next;
    end

    // Register the demand latches and their OR from the same next-state value
    // so any_req never lags t_req.
    always_ff @(posedge clk) begin
        if (reset) begin
            t_req_q   <= '0;
            any_req_q <= 1'b0;
        end else begin
            t_req_q   <= t_req_next;
            any_req_q <= |t_req_next;
        end
    end

    assign bus.t_req   = t_req_q;
    assign bus.sensed  = sensed_w;
    assign bus.any_req = any_req_q;
    assign bus.stuck   = stuck_q;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner: directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural model.
// Build with STUCK_DETECT_EN defined to also exercise the stuck detector.
module tb_traffic_sensor_conditioner;
    import traffic_pkg::*;

    localparam int DEB     = 8;
    localparam int DB_W    = 4;
    localparam int SC      = 20;
    localparam int STUCK_W = 5;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    traffic_sensor_conditioner_if ifc ();

    traffic_sensor_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .DB_W            (DB_W),
        .STUCK_CYCLES    (SC),
        .STUCK_W         (STUCK_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: synchroniser taps, debounced level (current and
    // one cycle older), run of disagreeing samples, high-time per lane.
    lane_mask_t m_s1, m_s2, m_sensed, m_sensed_old, m_treq, m_stuck;
    logic       m_any;
    int         m_run  [NUM_LANES];
    int         m_high [NUM_LANES];

    // Advance the model one clock edge from the inputs present at that edge.
    task automatic modelStep(input lane_mask_t raw_v, input lane_mask_t side_v,
                             input logic next_v, input logic rst_v);
        lane_mask_t arrived, new_sensed, served, new_stuck, new_treq;
        if (rst_v) begin
            m_s1 = '0; m_s2 = '0; m_sensed = '0; m_sensed_old = '0;
            m_treq = '0; m_stuck = '0; m_any = 1'b0;
            for (int i = 0; i < NUM_LANES; i++) begin
                m_run[i] = 0; m_high[i] = 0;
            end
        end else begin
            arrived    = m_sensed & ~m_sensed_old;
            new_sensed = m_sensed;
            new_stuck  = '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                if (m_s2[i] != m_sensed[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= DEB) begin
                        new_sensed[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_high[i] = m_sensed[i] ? ((m_high[i] + 1 > SC) ? SC : m_high[i] + 1) : 0;
`ifdef STUCK_DETECT_EN
                new_stuck[i] = m_sensed[i] && (m_stuck[i] || (m_high[i] == SC));
`endif
            end
            served       = (next_v && ($countones(side_v) == 1)) ? side_v : '0;
            new_treq     = (arrived | (m_treq & ~served)) & ~new_stuck;
            m_any        = |new_treq;
            m_treq       = new_treq;
            m_stuck      = new_stuck;
            m_sensed_old = m_sensed;
            m_sensed     = new_sensed;
            m_s2         = m_s1;
            m_s1         = raw_v;
        end
    endtask

    task automatic compareBits(input string tag, input logic [3:0] observed,
                               input logic [3:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        compareBits({tag, "_t_req"},   ifc.t_req,           m_treq);
        compareBits({tag, "_sensed"},  ifc.sensed,          m_sensed);
        compareBits({tag, "_any_req"}, {3'b000, ifc.any_req}, {3'b000, m_any});
        compareBits({tag, "_stuck"},   ifc.stuck,           m_stuck);
    endtask

    // Drive one cycle of inputs, clock it, update the model, compare mid-cycle.
    task automatic applyStimulus(input string tag, input lane_mask_t raw_v,
                                 input lane_mask_t side_v, input logic next_v,
                                 input logic rst_v);
        ifc.raw_in = raw_v;
        ifc.side   = side_v;
        ifc.next   = next_v;
        reset      = rst_v;
        @(posedge clk);
        modelStep(raw_v, side_v, next_v, rst_v);
        #2;
        checkOutput(tag);
    endtask

    task automatic idle(input string tag, input lane_mask_t raw_v, input int n);
        for (int k = 0; k < n; k++) applyStimulus(tag, raw_v, '0, 1'b0, 1'b0);
    endtask

    task automatic serveAll(input string tag);
        applyStimulus(tag, '0, LANE1, 1'b1, 1'b0);
        applyStimulus(tag, '0, LANE2, 1'b1, 1'b0);
        applyStimulus(tag, '0, LANE3, 1'b1, 1'b0);
        applyStimulus(tag, '0, LANE4, 1'b1, 1'b0);
    endtask

    initial begin
        lane_mask_t raw_r, side_r;
        logic       next_r;
        tests_run    = 0;
        tests_failed = 0;
        ifc.raw_in = 4'hF; ifc.side = '0; ifc.next = 1'b0; reset = 1'b1;

        // Reset held with all sensors active: everything stays low.
        for (int k = 0; k < 3; k++) applyStimulus("reset", 4'hF, '0, 1'b0, 1'b1);
        compareBits("reset_t_req_zero", ifc.t_req, 4'h0);
        idle("latency", 4'hF, 10);
        compareBits("latency_edge10", ifc.t_req, 4'h0);
        idle("latency", 4'hF, 1);
        compareBits("latency_edge11", ifc.t_req, 4'hF);
        compareBits("latency_any", {3'b000, ifc.any_req}, 4'h1);

        idle("drain", '0, 12);
        serveAll("serve_all");

        // A 7-cycle glitch on lane2 never reaches the outputs.
        idle("glitch7", LANE2, 7);
        idle("glitch7", '0, 12);
        compareBits("glitch7_t_req", ifc.t_req, 4'h0);
        compareBits("glitch7_sensed", ifc.sensed, 4'h0);

        // An 8-cycle pulse does, 11 edges after it starts.
        idle("pulse8", LANE2, 8);
        idle("pulse8", '0, 2);
        compareBits("pulse8_edge10", ifc.t_req, 4'h0);
        idle("pulse8", '0, 1);
        compareBits("pulse8_edge11", ifc.t_req, LANE2);
        idle("pulse8", '0, 12);
        applyStimulus("pulse8_srv", '0, LANE2, 1'b1, 1'b0);

        // Service clears only the lane that had the phase.
        idle("service", LANE1 | LANE3, 11);
        idle("service", '0, 12);
        compareBits("service_pre", ifc.t_req, 4'b0101);
        applyStimulus("service1", '0, LANE1, 1'b1, 1'b0);
        compareBits("service1_t_req", ifc.t_req, 4'b0100);
        compareBits("service1_any", {3'b000, ifc.any_req}, 4'h1);
        applyStimulus("service3", '0, LANE3, 1'b1, 1'b0);
        compareBits("service3_t_req", ifc.t_req, 4'b0000);
        compareBits("service3_any", {3'b000, ifc.any_req}, 4'h0);

        // Arrival in the same cycle as the clear keeps the request.
        idle("simul", LANE1, 11);
        idle("simul", '0, 12);
        idle("simul", LANE1, 10);
        applyStimulus("simul_clr", LANE1, LANE1, 1'b1, 1'b0);
        compareBits("simul_t_req", ifc.t_req, LANE1);

        // A car left on the loop after service does not re-request.
        applyStimulus("rereq_srv", LANE1, LANE1, 1'b1, 1'b0);
        idle("rereq", LANE1, 5);
        compareBits("rereq_t_req", ifc.t_req, 4'h0);
        idle("rereq", '0, 12);

        // Malformed side masks clear nothing.
        idle("badside", LANE1 | LANE4, 11);
        idle("badside", '0, 12);
        applyStimulus("badside_zero", '0, 4'b0000, 1'b1, 1'b0);
        compareBits("badside_zero_t_req", ifc.t_req, 4'b1001);
        applyStimulus("badside_multi", '0, 4'b0011, 1'b1, 1'b0);
        compareBits("badside_multi_t_req", ifc.t_req, 4'b1001);

        // Randomized traffic, glitches, service pulses and a mid-run reset.
        raw_r = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NUM_LANES; i++)
                if ($urandom_range(0, 11) == 0) raw_r[i] = ~raw_r[i];
            side_r = ($urandom_range(0, 7) == 0) ? lane_mask_t'($urandom_range(0, 15))
                                                 : lane_mask_t'(1 << $urandom_range(0, 3));
            next_r = ($urandom_range(0, 5) == 0);
            applyStimulus("random", raw_r, side_r, next_r, (k >= 200) && (k < 202));
        end

        idle("cleanup", '0, 12);
        serveAll("cleanup_srv");

`ifdef STUCK_DETECT_EN
        // A loop held high too long is flagged and its demand withdrawn.
        idle("stuck", LANE4, 40);
        compareBits("stuck_flag", ifc.stuck, LANE4);
        compareBits("stuck_t_req", ifc.t_req & LANE4, 4'h0);
        idle("unstuck", '0, 12);
        compareBits("unstuck_flag", ifc.stuck, 4'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
